// File: rtl/bird_motion_if.sv
// Player-facing control/status bundle for the bird motion block.
// The block drives the status signals; the game logic drives the controls.
interface bird_motion_if #(
  parameter int ROWS = 16
);
  localparam int RW = $clog2(ROWS);

  logic          pause;
  logic          tick;
  logic          flap;
  logic          collide;
  logic [RW-1:0] bird_row;
  logic          dead;
  logic          flying;

  modport master (
    output pause, tick, flap, collide,
    input  bird_row, dead, flying
  );

  modport slave (
    input  pause, tick, flap, collide,
    output bird_row, dead, flying
  );
endinterface

// File: rtl/bird_motion.sv
// Vertical bird motion: waits for the first flap, climbs RISE_ROWS gravity ticks
// per press, falls one row per tick otherwise, and dies on the floor or on a pipe.
module bird_motion #(
  parameter int ROWS      = 16,
  parameter int START_ROW = 7,
  parameter int RISE_ROWS = 2
) (
  input  logic       clk,
  input  logic       reset,
  bird_motion_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = (RISE_ROWS < 1) ? 1 : $clog2(RISE_ROWS + 1);

  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [RW-1:0] ROW_FLOOR = RW'(ROWS - 1);
  localparam logic [CW-1:0] RISE_FULL = CW'(RISE_ROWS);
  localparam logic [CW-1:0] RISE_NEXT = CW'(RISE_ROWS - 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_FLY  = 2'd1,
    S_DEAD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] rise_q, rise_d;
  logic          flap_q;
  logic          dead_q, dead_d;
  logic          flying_q, flying_d;

  logic          press;
  logic [RW-1:0] row_up;

  assign press = bus.flap & ~flap_q;
  // Climbing at the ceiling holds row 0 rather than wrapping.
  assign row_up = (row_q == '0) ? '0 : row_q - RW'(1);

  // Sampled even while paused so a press made during pause is dropped, not queued.
  always_ff @(posedge clk) begin
    if (reset) flap_q <= 1'b0;
    else       flap_q <= bus.flap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_WAIT;
      row_q    <= ROW_START;
      rise_q   <= '0;
      dead_q   <= 1'b0;
      flying_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      rise_q   <= rise_d;
      dead_q   <= dead_d;
      flying_q <= flying_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rise_d  = rise_q;

    if (!bus.pause) begin
      unique case (state_q)
        S_WAIT: begin
          if (press) begin
            state_d = S_FLY;
            rise_d  = RISE_FULL;
          end
        end

        S_FLY: begin
          // Priority: pipe hit, then press (with or without tick), then plain tick.
          if (bus.collide) begin
            state_d = S_DEAD;
          end else if (press && bus.tick) begin
            row_d  = row_up;
            rise_d = RISE_NEXT;
          end else if (press) begin
            rise_d = RISE_FULL;
          end else if (bus.tick) begin
            if (rise_q != '0) begin
              row_d  = row_up;
              rise_d = rise_q - CW'(1);
            end else if (row_q == ROW_FLOOR) begin
              state_d = S_DEAD;
            end else begin
              row_d = row_q + RW'(1);
            end
          end
        end

        S_DEAD: ;

        default: state_d = S_WAIT;
      endcase
    end

    dead_d   = (state_d == S_DEAD);
    flying_d = (state_d == S_FLY);
  end

  assign bus.bird_row = row_q;
  assign bus.dead     = dead_q;
  assign bus.flying   = flying_q;
endmodule
